// File: rtl/fp_mul_pkg.sv
// Shared float-format constants, id-width helper and in-flight tag type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_mul_pkg;

  localparam int EXPONENT_WIDTH = 8;
  localparam int MANTISSA_WIDTH = 23;
  localparam int FP_W           = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam int BIAS           = (1 << (EXPONENT_WIDTH - 1)) - 1;

  // Widest id the tag can carry; covers up to 16 requesters.
  localparam int TAG_ID_W = 4;

  // Requester-index width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters, search starts at the pointer and wraps.
// Latency: grant is combinational from req; pointer updates on the advance edge.
// Backpressure: a requester holds req until it sees its grant bit.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  import fp_mul_pkg::*;

  localparam int PW = id_width(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;

  // First requester at or after ptr (with wrap) wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        gidx  = PW'((int'(ptr) + k) % N);
        grant[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

  // Move the pointer just past the winner so it has lowest priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one registered float multiplier among NUM_REQ requesters, routing products back by id.
// Latency: MUL_LAT+1 cycles from handshake edge to res_valid; one issue per cycle.
// Backpressure: per-requester valid/ready on issue; results are never stalled.
module fp_mul_arbiter #(
  parameter int  NUM_REQ        = 4,
  parameter int  EXPONENT_WIDTH = 8,
  parameter int  MANTISSA_WIDTH = 23,
  parameter int  MUL_LAT        = 1,
  localparam int FP_W           = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  localparam int ID_W           = fp_mul_pkg::id_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*FP_W-1:0]     req_a,
  input  logic [NUM_REQ*FP_W-1:0]     req_b,
  output logic [FP_W-1:0]             mul_a,
  output logic [FP_W-1:0]             mul_b,
  input  logic                        mul_sign,
  input  logic [EXPONENT_WIDTH-1:0]   mul_exponent,
  input  logic [MANTISSA_WIDTH-1:0]   mul_prod,
  output logic [NUM_REQ-1:0]          res_valid,
  output logic [FP_W-1:0]             res_data,
  output logic [ID_W-1:0]             res_id,
  output logic                        busy
);
  import fp_mul_pkg::*;

  logic [NUM_REQ-1:0] grant;
  logic               handshake;
  logic [ID_W-1:0]    grant_id;
  logic [FP_W-1:0]    grant_a;
  logic [FP_W-1:0]    grant_b;
  tag_t               tag_q [MUL_LAT+1];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (handshake),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign handshake = |grant;

  // Encode the one-hot grant and select the winner's operands.
  always_comb begin
    grant_id = '0;
    grant_a  = '0;
    grant_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        grant_a  = req_a[i*FP_W +: FP_W];
        grant_b  = req_b[i*FP_W +: FP_W];
      end
    end
  end

  // Issue operands and walk the id tag alongside the multiplier pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      if (handshake) begin
        mul_a <= grant_a;
        mul_b <= grant_b;
      end
      tag_q[0] <= '{valid: handshake, id: TAG_ID_W'(grant_id)};
      for (int k = 1; k <= MUL_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Capture the product when its tag reaches the multiplier output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= '0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (tag_q[MUL_LAT].valid) begin
      res_valid <= NUM_REQ'(1) << tag_q[MUL_LAT].id;
      res_id    <= tag_q[MUL_LAT].id[ID_W-1:0];
      res_data  <= {mul_sign, mul_exponent, mul_prod};
    end else begin
      res_valid <= '0;
    end
  end

  // Busy while anything is in flight or a result is being presented.
  always_comb begin
    busy = |res_valid;
    for (int k = 0; k <= MUL_LAT; k++) begin
      busy = busy | tag_q[k].valid;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: default build plus a MUL_LAT=3 build, each fed by a behavioural multiplier.
// Latency: results are checked against issue cycle + MUL_LAT + 1.
// Backpressure: none on results; scoreboard order follows issue order.
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Main build (MUL_LAT=1)
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, res_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   mul_a, mul_b, res_data, mout;
  logic           mul_sign;
  logic [7:0]     mul_exponent;
  logic [22:0]    mul_prod;
  logic [1:0]     res_id;
  logic           busy;

  // Pipelined build (MUL_LAT=3)
  logic           rst3_n;
  logic [N-1:0]   req_valid3, req_ready3, res_valid3;
  logic [N*W-1:0] req_a3, req_b3;
  logic [W-1:0]   mul_a3, mul_b3, res_data3, m3_s0, m3_s1, m3_s2;
  logic [1:0]     res_id3;
  logic           busy3;

  sb_t         sb[$];
  sb_t         sb3[$];
  int          glog[$];
  int          glog3[$];
  logic [31:0] exp_prod [N];
  logic [31:0] exp_prod3 [N];
  sb_t         e_m, e_m3;

  // Truncating float multiply standing in for the external fpMul.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic [22:0] m;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 32'd0;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], 8'(e), m};
  endfunction

  always @(posedge clk) mout <= fmul(mul_a, mul_b);
  assign {mul_sign, mul_exponent, mul_prod} = mout;

  always @(posedge clk) begin
    m3_s0 <= fmul(mul_a3, mul_b3);
    m3_s1 <= m3_s0;
    m3_s2 <= m3_s1;
  end

  fp_mul_arbiter #(.NUM_REQ(N), .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .MUL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_exponent(mul_exponent), .mul_prod(mul_prod),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  fp_mul_arbiter #(.NUM_REQ(N), .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .mul_a(mul_a3), .mul_b(mul_b3),
    .mul_sign(m3_s2[31]), .mul_exponent(m3_s2[30:23]), .mul_prod(m3_s2[22:0]),
    .res_valid(res_valid3), .res_data(res_data3), .res_id(res_id3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the main build: pop on result, push on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid != '0) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL res_unexpected observed=%b expected=no result", res_valid);
        end
        if (sb.size() > 0) begin
          e_m = sb.pop_front();
          chk("res_valid", 32'(res_valid), 32'(4'b0001 << e_m.id));
          chk("res_id", 32'(res_id), 32'(e_m.id));
          chk("res_data", res_data, e_m.data);
          chk("res_latency", 32'(cyc), 32'(e_m.due));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: 2'(i), data: exp_prod[i], due: cyc + 1 + 2});
          glog.push_back(i);
        end
      end
    end
  end

  // Scoreboard for the MUL_LAT=3 build.
  always @(negedge clk) begin
    if (rst3_n) begin
      if (res_valid3 != '0) begin
        checks++;
        assert (sb3.size() > 0) else begin
          errors++;
          $error("FAIL res3_unexpected observed=%b expected=no result", res_valid3);
        end
        if (sb3.size() > 0) begin
          e_m3 = sb3.pop_front();
          chk("res3_valid", 32'(res_valid3), 32'(4'b0001 << e_m3.id));
          chk("res3_id", 32'(res_id3), 32'(e_m3.id));
          chk("res3_data", res_data3, e_m3.data);
          chk("res3_latency", 32'(cyc), 32'(e_m3.due));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid3[i] && req_ready3[i]) begin
          sb3.push_back('{id: 2'(i), data: exp_prod3[i], due: cyc + 3 + 2});
          glog3.push_back(i);
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    exp_prod[i]     = p;
  endtask

  task automatic set_op3(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    req_a3[i*W +: W] = a;
    req_b3[i*W +: W] = b;
    exp_prod3[i]     = p;
  endtask

  // Wait for the selected build to drain, bounded.
  task automatic wait_idle(input bit which);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      idle = which ? (!busy3 && sb3.size() == 0) : (!busy && sb.size() == 0);
    end
    checks++;
    assert (idle) else begin
      errors++;
      $error("FAIL drain_timeout observed=busy expected=idle build=%0d", which);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord_c[8];
    int ord_f[4];
    int rv_seen;
    ord_c = '{0, 1, 2, 3, 0, 1, 2, 3};
    ord_f = '{3, 1, 3, 1};

    rst_n = 1'b0; rst3_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0;
    for (int i = 0; i < N; i++) begin
      exp_prod[i] = '0;
      exp_prod3[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; rst3_n = 1'b1;

    // Contention: all four held valid, 1.5*1.5
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_op(i, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    req_valid = 4'b1111;
    repeat (8) @(posedge clk);
    #1 req_valid = '0;
    wait_idle(1'b0);
    chk("cont_count", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("cont_order", 32'(glog[i]), 32'(ord_c[i]));

    // Single issue from req0: 2.0*3.0
    @(posedge clk); #1;
    set_op(0, 32'h40000000, 32'h40400000, 32'h40C00000);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("single_busy0", 32'(busy), 32'd1);
    chk("single_mul_a", mul_a, 32'h40000000);
    chk("single_mul_b", mul_b, 32'h40400000);
    @(negedge clk);
    chk("single_busy1", 32'(busy), 32'd1);
    chk("single_no_early", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("single_res_valid", 32'(res_valid), 32'b0001);
    chk("single_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_busy_end", 32'(busy), 32'd0);
    chk("single_res_drop", 32'(res_valid), 32'd0);
    wait_idle(1'b0);

    // One issue from req1 moves the pointer to 2
    @(posedge clk); #1;
    set_op(1, 32'h40000000, 32'h40400000, 32'h40C00000);
    req_valid = 4'b0010;
    @(posedge clk); #1 req_valid = '0;
    wait_idle(1'b0);

    // Fairness and wrap: req1 and req3 held from ptr=2
    glog.delete();
    @(posedge clk); #1;
    set_op(1, 32'h3FC00000, 32'h40000000, 32'h40400000);
    set_op(3, 32'h40400000, 32'h40400000, 32'h41100000);
    req_valid = 4'b1010;
    repeat (4) @(posedge clk);
    #1 req_valid = '0;
    wait_idle(1'b0);
    chk("fair_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("fair_order", 32'(glog[i]), 32'(ord_f[i]));

    // Zero operand on req2
    @(posedge clk); #1;
    set_op(2, 32'h00000000, 32'hC1200000, 32'h00000000);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("zero_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(1'b0);
    chk("zero_res_id", 32'(res_id), 32'd2);
    chk("zero_res_data", res_data, 32'h00000000);

    // MUL_LAT=3: back-to-back from req1, results on consecutive cycles
    @(posedge clk); #1;
    set_op3(1, 32'h40000000, 32'h3F800000, 32'h40000000);
    req_valid3 = 4'b0010;
    @(posedge clk); #1;
    set_op3(1, 32'h40000000, 32'h40800000, 32'h41000000);
    @(posedge clk); #1 req_valid3 = '0;
    wait_idle(1'b1);
    chk("lat3_count", 32'(glog3.size()), 32'd2);

    // Reset mid-flight on the MUL_LAT=3 build
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_op3(i, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    req_valid3 = 4'b0111;
    repeat (3) @(posedge clk);
    #1 req_valid3 = '0;
    @(posedge clk); #1;
    rst3_n = 1'b0;
    sb3.delete();
    #1;
    chk("mid_rst_ready", 32'(req_ready3), 32'd0);
    chk("mid_rst_mul_a", mul_a3, 32'd0);
    chk("mid_rst_mul_b", mul_b3, 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid3), 32'd0);
    chk("mid_rst_res_data", res_data3, 32'd0);
    chk("mid_rst_res_id", 32'(res_id3), 32'd0);
    chk("mid_rst_busy", 32'(busy3), 32'd0);
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid3 != '0) rv_seen++;
    end
    rst3_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (res_valid3 != '0) rv_seen++;
    end
    chk("mid_rst_no_result", 32'(rv_seen), 32'd0);
    chk("mid_rst_busy_after", 32'(busy3), 32'd0);

    // First issue after reset starts from req0
    @(posedge clk); #1;
    req_valid3 = 4'b0101;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready3), 32'b0001);
    @(posedge clk); #1 req_valid3 = '0;
    wait_idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
